// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: arbitrates ALU/load results into an in-order FIFO and retires one register write per cycle.
// Optional combinational operand bypass from pending entries is enabled by defining WB_BYPASS_EN.
module regfile_wb_ctrl #(
    parameter int add_width  = 5,
    parameter int data_width = 32,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alu_valid,
    input  logic [add_width-1:0]          alu_rd,
    input  logic [data_width-1:0]         alu_data,
    output logic                          alu_ready,
    input  logic                          mem_valid,
    input  logic [add_width-1:0]          mem_rd,
    input  logic [data_width-1:0]         mem_data,
    output logic                          mem_ready,
    input  logic                          wb_stall,
    output logic [add_width-1:0]          add_rd,
    output logic [data_width-1:0]         write_data,
    output logic                          regwrite,
    output logic [(2**add_width)-1:0]     busy_mask,
    output logic [$clog2(DEPTH):0]        count
`ifdef WB_BYPASS_EN
    ,
    input  logic [add_width-1:0]          byp_rs1,
    input  logic [add_width-1:0]          byp_rs2,
    output logic                          byp_hit1,
    output logic                          byp_hit2,
    output logic [data_width-1:0]         byp_data1,
    output logic [data_width-1:0]         byp_data2
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2 ** add_width;

    logic [add_width-1:0]  rd_mem_r   [DEPTH];
    logic [data_width-1:0] data_mem_r [DEPTH];
    logic [DEPTH-1:0]      valid_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  full_r;

    logic                  empty_s;
    logic                  push_s;
    logic                  pop_s;
    logic [add_width-1:0]  push_rd_s;
    logic [data_width-1:0] push_data_s;
    logic [CNT_W-1:0]      count_nxt_s;
    logic [NREG-1:0]       busy_s;

    // Handshake, arbitration (memory wins) and push/pop qualification.
    always_comb begin
        empty_s     = (count_r == {CNT_W{1'b0}});
        mem_ready   = !full_r;
        alu_ready   = !full_r && !mem_valid;
        pop_s       = !empty_s && !wb_stall;
        push_s      = 1'b0;
        push_rd_s   = alu_rd;
        push_data_s = alu_data;
        if (mem_valid) begin
            push_s      = !full_r;
            push_rd_s   = mem_rd;
            push_data_s = mem_data;
        end else begin
            push_s      = alu_valid && !full_r;
        end
    end

    // Next occupancy from the push/pop pair.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage, pointers, occupancy and the registered full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_r[i]   <= {add_width{1'b0}};
                data_mem_r[i] <= {data_width{1'b0}};
            end
            valid_r  <= {DEPTH{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            full_r   <= 1'b0;
        end else begin
            if (pop_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r          <= rd_ptr_r;
            end
            // A push never lands on the slot being popped: that needs full, which blocks pushes.
            if (push_s) begin
                rd_mem_r[wr_ptr_r]   <= push_rd_s;
                data_mem_r[wr_ptr_r] <= push_data_s;
                valid_r[wr_ptr_r]    <= 1'b1;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r             <= wr_ptr_r;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_W'(DEPTH));
        end
    end

    // Register file write port driven from the FIFO head; x0 entries retire silently.
    always_comb begin
        if (empty_s) begin
            add_rd     = {add_width{1'b0}};
            write_data = {data_width{1'b0}};
            regwrite   = 1'b0;
        end else begin
            add_rd     = rd_mem_r[rd_ptr_r];
            write_data = data_mem_r[rd_ptr_r];
            regwrite   = !wb_stall && (rd_mem_r[rd_ptr_r] != {add_width{1'b0}});
        end
    end

    // Pending-destination mask for hazard detection.
    always_comb begin
        busy_s = {NREG{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_r[i]) begin
                busy_s[rd_mem_r[i]] = 1'b1;
            end else begin
                busy_s = busy_s;
            end
        end
        busy_s[0] = 1'b0;
    end

    assign busy_mask = busy_s;
    assign count     = count_r;

`ifdef WB_BYPASS_EN
    logic [PTR_W-1:0] byp_idx_s;

    // Scan oldest to youngest so the youngest matching entry overrides earlier ones.
    always_comb begin
        byp_hit1  = 1'b0;
        byp_hit2  = 1'b0;
        byp_data1 = {data_width{1'b0}};
        byp_data2 = {data_width{1'b0}};
        byp_idx_s = rd_ptr_r;
        for (int k = 0; k < DEPTH; k++) begin
            byp_idx_s = rd_ptr_r + PTR_W'(k);
            if (valid_r[byp_idx_s] && (byp_rs1 != {add_width{1'b0}}) &&
                (rd_mem_r[byp_idx_s] == byp_rs1)) begin
                byp_hit1  = 1'b1;
                byp_data1 = data_mem_r[byp_idx_s];
            end else begin
                byp_hit1  = byp_hit1;
            end
            if (valid_r[byp_idx_s] && (byp_rs2 != {add_width{1'b0}}) &&
                (rd_mem_r[byp_idx_s] == byp_rs2)) begin
                byp_hit2  = 1'b1;
                byp_data2 = data_mem_r[byp_idx_s];
            end else begin
                byp_hit2  = byp_hit2;
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed, table-driven bench for regfile_wb_ctrl (define WB_BYPASS_EN to also cover the bypass ports).
module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, mem_valid, wb_stall;
    logic [4:0]  alu_rd, mem_rd;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, regwrite;
    logic [4:0]  add_rd;
    logic [31:0] write_data, busy_mask;
    logic [2:0]  count;
`ifdef WB_BYPASS_EN
    logic [4:0]  byp_rs1, byp_rs2;
    logic        byp_hit1, byp_hit2;
    logic [31:0] byp_data1, byp_data2;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    regfile_wb_ctrl #(.add_width(5), .data_width(32), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .wb_stall(wb_stall), .add_rd(add_rd), .write_data(write_data), .regwrite(regwrite),
        .busy_mask(busy_mask), .count(count)
`ifdef WB_BYPASS_EN
        , .byp_rs1(byp_rs1), .byp_rs2(byp_rs2), .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
        .byp_data1(byp_data1), .byp_data2(byp_data2)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;   logic [4:0] ard; logic [31:0] ad;
        logic        mv;   logic [4:0] mrd; logic [31:0] md;
        logic        st;
        logic        e_ar; logic        e_mr;
        logic        e_rw; logic [4:0] e_rd; logic [31:0] e_wd;
        logic [2:0]  e_cnt; logic [31:0] e_busy;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
    endtask

    task automatic post_checks(input string tag, input logic rw, input logic [4:0] rd,
                               input logic [31:0] wd, input logic [2:0] cnt, input logic [31:0] busy);
        chk({tag, ".regwrite"},   32'(regwrite),   32'(rw));
        chk({tag, ".add_rd"},     32'(add_rd),     32'(rd));
        chk({tag, ".write_data"}, write_data,      wd);
        chk({tag, ".count"},      32'(count),      32'(cnt));
        chk({tag, ".busy_mask"},  busy_mask,       busy);
    endtask

    initial begin
        //          av    ard    ad            mv    mrd    md          st    ar    mr    rw    rd     wd            cnt   busy
        vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,      1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 3'd1, 32'h0000_0020};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0, 32'h0};
        vecs[2]  = '{1'b1, 5'd4, 32'h22,       1'b1, 5'd3, 32'h11,     1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'h11,       3'd1, 32'h0000_0008};
        vecs[3]  = '{1'b1, 5'd4, 32'h22,       1'b0, 5'd0, 32'h0,      1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 32'h22,       3'd1, 32'h0000_0010};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0, 32'h0};
        vecs[5]  = '{1'b1, 5'd1, 32'hA1,       1'b0, 5'd0, 32'h0,      1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 32'hA1,       3'd1, 32'h0000_0002};
        vecs[6]  = '{1'b1, 5'd2, 32'hA2,       1'b0, 5'd0, 32'h0,      1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 32'hA1,       3'd2, 32'h0000_0006};
        vecs[7]  = '{1'b1, 5'd3, 32'hA3,       1'b0, 5'd0, 32'h0,      1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 32'hA1,       3'd3, 32'h0000_000E};
        vecs[8]  = '{1'b1, 5'd4, 32'hA4,       1'b0, 5'd0, 32'h0,      1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 32'hA1,       3'd4, 32'h0000_001E};
        vecs[9]  = '{1'b1, 5'd5, 32'hA5,       1'b0, 5'd0, 32'h0,      1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'hA1,       3'd4, 32'h0000_001E};
        vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'hA2,       3'd3, 32'h0000_001C};
        vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'hA3,       3'd2, 32'h0000_0018};
        vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 32'hA4,       3'd1, 32'h0000_0010};
        vecs[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0, 32'h0};
        vecs[14] = '{1'b1, 5'd0, 32'h55,       1'b0, 5'd0, 32'h0,      1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h55,       3'd1, 32'h0};
        vecs[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0, 32'h0};
        vecs[16] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h99,     1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 32'h99,       3'd1, 32'h0000_0200};
        vecs[17] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd10, 32'h100,   1'b0, 1'b0, 1'b1, 1'b1, 5'd10, 32'h100,     3'd1, 32'h0000_0400};
        vecs[18] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0, 32'h0};

        rst_n = 1'b0; wb_stall = 1'b0;
        idle_inputs();
`ifdef WB_BYPASS_EN
        byp_rs1 = 5'd0; byp_rs2 = 5'd0;
`endif
        repeat (2) @(posedge clk);
        #1;
        post_checks("reset", 1'b0, 5'd0, 32'h0, 3'd0, 32'h0);
        chk("reset.alu_ready", 32'(alu_ready), 32'd1);
        chk("reset.mem_ready", 32'(mem_ready), 32'd1);
        rst_n = 1'b1;

        // Table: readies are checked before the edge, FIFO/head state just after it.
        for (int i = 0; i < NV; i++) begin
            alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].ad;
            mem_valid = vecs[i].mv; mem_rd = vecs[i].mrd; mem_data = vecs[i].md;
            wb_stall  = vecs[i].st;
            #1;
            chk($sformatf("v%0d.alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_ar));
            chk($sformatf("v%0d.mem_ready", i), 32'(mem_ready), 32'(vecs[i].e_mr));
            @(posedge clk);
            #1;
            post_checks($sformatf("v%0d", i), vecs[i].e_rw, vecs[i].e_rd, vecs[i].e_wd,
                        vecs[i].e_cnt, vecs[i].e_busy);
        end
        idle_inputs();
        wb_stall = 1'b0;

        // Asynchronous reset in the middle of a cycle with three entries queued under stall.
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(6 + i); alu_data = 32'(32'h60 + i);
            @(posedge clk);
            #1;
        end
        idle_inputs();
        chk("rst_mid.count_before", 32'(count), 32'd3);
        chk("rst_mid.busy_before", busy_mask, 32'h0000_01C0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid.count", 32'(count), 32'd0);
        chk("rst_mid.regwrite", 32'(regwrite), 32'd0);
        chk("rst_mid.busy_mask", busy_mask, 32'h0);
        chk("rst_mid.add_rd", 32'(add_rd), 32'd0);
        chk("rst_mid.alu_ready", 32'(alu_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wb_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("rst_after%0d.regwrite", i), 32'(regwrite), 32'd0);
            chk($sformatf("rst_after%0d.count", i), 32'(count), 32'd0);
            @(posedge clk);
            #1;
        end

`ifdef WB_BYPASS_EN
        // Two pending writes to x7: the younger value must be forwarded.
        wb_stall = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h1;
        @(posedge clk);
        #1;
        alu_data = 32'h2;
        @(posedge clk);
        #1;
        idle_inputs();
        byp_rs1 = 5'd7; byp_rs2 = 5'd0;
        #1;
        chk("byp.hit1", 32'(byp_hit1), 32'd1);
        chk("byp.data1", byp_data1, 32'h2);
        chk("byp.hit2_x0", 32'(byp_hit2), 32'd0);
        chk("byp.data2_x0", byp_data2, 32'h0);
        byp_rs2 = 5'd9;
        #1;
        chk("byp.hit2_miss", 32'(byp_hit2), 32'd0);
        wb_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("byp.hit1_drained", 32'(byp_hit1), 32'd0);
        chk("byp.count_drained", 32'(count), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Writeback controller that owns the register file write port (add_rd, write_data, regwrite). Collects results from two producers, the single-cycle ALU and the multi-cycle memory/load path, through valid/ready handshakes. Arbitrates between them, buffers accepted results in a small in-order FIFO, and retires one write per cycle into the register file. Keeps a busy mask of pending destinations for hazard detection and can optionally forward pending data to operand readers.

## Interface
- add_width, 5, register address width; the register file holds 2**add_width entries
- data_width, 32, register data width
- DEPTH, 4, FIFO entries; must be a power of two, minimum 2
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- alu_valid  input  1  ALU result offered
- alu_rd  input  add_width  ALU destination register
- alu_data  input  data_width  ALU result
- alu_ready  output  1  ALU result accepted this cycle when alu_valid is also high
- mem_valid  input  1  load result offered
- mem_rd  input  add_width  load destination register
- mem_data  input  data_width  load result
- mem_ready  output  1  load result accepted this cycle when mem_valid is also high
- wb_stall  input  1  write port unavailable; hold the FIFO head
- add_rd  output  add_width  register file write address
- write_data  output  data_width  register file write data
- regwrite  output  1  register file write enable
- busy_mask  output  2**add_width  bit r is set while any FIFO entry targets r (bit 0 is always 0)
- count  output  $clog2(DEPTH)+1  current FIFO occupancy
- byp_rs1, byp_rs2  input  add_width  bypass query addresses (only with WB_BYPASS_EN)
- byp_hit1, byp_hit2  output  1  a pending entry matches the query (only with WB_BYPASS_EN)
- byp_data1, byp_data2  output  data_width  data from the youngest matching entry (only with WB_BYPASS_EN)

## Operation
- Arbitration uses fixed priority, memory first:
  - mem_ready = !full.
  - alu_ready = !full && !mem_valid.
  - At most one push per cycle.
- Push: on a clock edge with an accepted handshake, {rd, data} is written at the write pointer, the write pointer increments modulo DEPTH, and count increments.
- Head drive (combinational from the head entry):
  - add_rd = head rd.
  - write_data = head data.
  - regwrite = !empty && !wb_stall && head rd != 0.
  - When empty, add_rd and write_data drive 0.
- Pop: on each edge where !empty && !wb_stall, the read pointer increments and count decrements. An entry with rd == 0 is popped without asserting regwrite, so x0 is never written.
- Push and pop in the same edge leave count unchanged.
- Readiness depends only on the registered full flag. A full FIFO accepts nothing that cycle, even if it pops.
- busy_mask is the OR of decoded rd over all valid entries, with bit 0 forced to 0. It is combinational from FIFO state.
- Ordering is strict FIFO. Two entries with the same rd retire in acceptance order.
- Reset (asynchronous, any time): pointers, count and all entry valid bits clear. Outputs are then regwrite=0, add_rd=0, write_data=0, busy_mask=0, count=0, alu_ready=1, mem_ready=1 (byp_hit*=0, byp_data*=0). In-flight entries are discarded.

## Timing
- Accept-to-write latency is one cycle. A result accepted at edge N appears as a regwrite during cycle N to N+1 and is written into the register file at edge N+1, with no wb_stall.
- There is no same-cycle pass-through from the producer to the register file.
- Sustained throughput is one write per cycle. With wb_stall held, the FIFO fills after DEPTH accepts, then both ready outputs drop.
- Pointer wrap-around is modulo DEPTH. Full = (count == DEPTH); empty = (count == 0).

## Configuration
- WB_BYPASS_EN:
  - Defined: the byp_* ports exist. byp_hitK = 1 when byp_rsK != 0 and matches a valid entry. byp_dataK is that entry's data; the youngest match wins. Otherwise byp_hitK = 0 and byp_dataK = 0. The path is purely combinational.
  - Undefined: the byp_* ports and the compare logic are absent.

## Test plan
- ALU only: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle, wb_stall=0. Required: regwrite=1, add_rd=5, write_data=0xDEADBEEF in the next cycle only; busy_mask[5]=1 for that cycle.
- Arbitration: both valid in the same cycle (mem_rd=3/0x11, alu_rd=4/0x22). Required: mem_ready=1 and alu_ready=0; rd 3 writes first and rd 4 writes one cycle later, once the ALU is retried.
- Full/stall: wb_stall=1 with 5 ALU offers. Required: 4 accepted, count=4, alu_ready=0 on the 5th. Releasing wb_stall retires 4 writes on consecutive cycles in order.
- x0 suppression: push rd=0 with data 0x55. Required: count goes 1→0 with regwrite never asserted; busy_mask stays 0.
- Reset mid-operation: 3 entries queued under stall, then rst_n low asynchronously mid-cycle. Required: count=0, regwrite=0 and busy_mask=0 immediately; no write occurs after release.
- Bypass (WB_BYPASS_EN): stall, then push rd=7/0x1 and rd=7/0x2, and query byp_rs1=7. Required: byp_hit1=1 and byp_data1=0x2. Query byp_rs2=0 → byp_hit2=0.
